// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory: capacity, fetch window and
// the loader state encoding used by both the writer and the read side.
package imem_pkg;

  localparam int          IMEM_BYTES       = 150;
  localparam logic [15:0] IMEM_FETCH_LIMIT = 16'h32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream into the loader plus the byte-wide write port it drives
// towards the instruction memory.
interface imem_loader_if #(
  parameter int ADDR_W = 16
);

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  // master: the loader; slave: stream source and memory on the other side
  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_loader.sv
// Writer side of the byte-wide instruction memory: takes a program image as a
// valid/ready byte stream and writes it little-endian from address 0.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int MAX_BYTES = IMEM_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  imem_loader_if.master     bus,
  output logic [ADDR_W-1:0] byte_count,
  output logic [7:0]        checksum,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] MAX_LEN = ADDR_W'(MAX_BYTES);

  loader_state_t     state_reg, state_next;
  logic [ADDR_W-1:0] len_reg, len_next;
  logic [ADDR_W-1:0] count_reg, count_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        sum_reg, sum_next;
  logic [7:0]        wdata_reg, wdata_next;
  logic              we_reg, we_next;
  logic              start_ok;
  logic              accept;

  assign start_ok = start && (state_reg != LOAD);
  assign accept   = bus.in_valid && (state_reg == LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      count_reg <= '0;
      addr_reg  <= '0;
      sum_reg   <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      count_reg <= count_next;
      addr_reg  <= addr_next;
      sum_reg   <= sum_next;
      wdata_reg <= wdata_next;
      we_reg    <= we_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    count_next = count_reg;
    addr_next  = addr_reg;
    sum_next   = sum_reg;
    wdata_next = wdata_reg;
    we_next    = 1'b0;

    if (start_ok) begin
      len_next   = len;
      count_next = '0;
      sum_next   = '0;
      // Odd lengths would leave half an instruction in memory
      if (len == '0)
        state_next = DONE;
      else if ((len > MAX_LEN) || len[0])
        state_next = ERR;
      else
        state_next = LOAD;
    end else if (accept) begin
      we_next    = 1'b1;
      addr_next  = count_reg;
      wdata_next = bus.in_data;
      count_next = count_reg + 1'b1;
      sum_next   = sum_reg ^ bus.in_data;
      if (count_next == len_reg)
        state_next = DONE;
    end
  end

  assign bus.in_ready  = (state_reg == LOAD);
  assign bus.mem_we    = we_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;

  assign byte_count = count_reg;
  assign checksum   = sum_reg;
  assign busy       = (state_reg == LOAD);
  assign cpu_hold   = busy;
  assign done       = (state_reg == DONE);
  assign err        = (state_reg == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: every accepted byte is pushed to a
// scoreboard and matched against the memory write one cycle later.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic [15:0] byte_count;
  logic [7:0]  checksum;
  logic        busy, cpu_hold, done, err;

  imem_loader_if #(.ADDR_W(16)) bus ();

  imem_loader #(.ADDR_W(16), .MAX_BYTES(150)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .bus        (bus),
    .byte_count (byte_count),
    .checksum   (checksum),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  logic [15:0] exp_addr = '0;
  logic [7:0]  exp_sum = '0;
  logic [7:0]  img [0:255];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    wr_t e;
    if (bus.mem_we === 1'b1) begin
      wr_cnt <= wr_cnt + 1;
      if (sb.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("we_cycle", cyc, e.cyc);
        check("we_addr", {16'd0, bus.mem_addr}, {16'd0, e.addr});
        check("we_data", {24'd0, bus.mem_wdata}, {24'd0, e.data});
        $display("write addr=%0d data=%02h cycle=%0d", bus.mem_addr, bus.mem_wdata, cyc);
      end
    end
  end

  // Caller sits at posedge+1; returns at posedge+1
  task automatic do_start(input logic [15:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start    = 1'b0;
    exp_addr = '0;
    exp_sum  = '0;
    $display("start len=%0d", l);
  endtask

  task automatic send_stream(input int first, input int n, input bit toggle);
    int i = 0;
    int guard = 0;
    bit phase = 1'b0;
    while (i < n && guard < 2000) begin
      bus.in_valid = toggle ? phase : 1'b1;
      bus.in_data  = img[first + i];
      phase = ~phase;
      @(negedge clk);
      check("busy_hold", {30'd0, busy, cpu_hold}, 32'd3);
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back('{cyc + 1, exp_addr, img[first + i]});
        exp_addr = exp_addr + 1'b1;
        exp_sum  = exp_sum ^ img[first + i];
        i++;
      end
      @(posedge clk); #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    if (guard >= 2000) check("stream_timeout", i, n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flags"}, {26'd0, bus.in_ready, bus.mem_we, busy, cpu_hold, done, err}, 32'd0);
    check({tag, "_addr"}, {16'd0, bus.mem_addr}, 32'd0);
    check({tag, "_wdata"}, {24'd0, bus.mem_wdata}, 32'd0);
    check({tag, "_count"}, {16'd0, byte_count}, 32'd0);
    check({tag, "_sum"}, {24'd0, checksum}, 32'd0);
  endtask

  task automatic check_finished(input string tag);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd0);
    check({tag, "_last_we"}, {31'd0, bus.mem_we}, 32'd1);
    check({tag, "_count"}, {16'd0, byte_count}, {16'd0, exp_addr});
    check({tag, "_sum"}, {24'd0, checksum}, {24'd0, exp_sum});
  endtask

  task automatic check_rejected(input string tag, input logic [15:0] l);
    int w0;
    do_start(l);
    w0 = wr_cnt;
    check({tag, "_err"}, {31'd0, err}, 32'd1);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_no_we"}, wr_cnt, w0);
    @(posedge clk); #1;
  endtask

  initial begin
    int w0;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    for (int k = 0; k < 256; k++) img[k] = 8'(k * 7 + 3);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: four bytes back-to-back
    img[0] = 8'h34; img[1] = 8'h12; img[2] = 8'h78; img[3] = 8'h56;
    do_start(16'd4);
    check("t1_busy", {31'd0, busy}, 32'd1);
    send_stream(0, 4, 1'b0);
    check_finished("t1");
    check("t1_sum_const", {24'd0, checksum}, 32'h08);

    // 2: six bytes with in_valid toggling
    for (int k = 0; k < 6; k++) img[k] = 8'(8'hA0 + k);
    @(posedge clk); #1;
    w0 = wr_cnt;
    do_start(16'd6);
    send_stream(0, 6, 1'b1);
    check_finished("t2");
    @(posedge clk); #1;
    check("t2_we_count", wr_cnt - w0, 32'd6);

    // 3: oversize and odd lengths rejected
    check_rejected("t3_151", 16'd151);
    check_rejected("t3_odd", 16'd5);

    // 4: empty image, then full capacity
    w0 = wr_cnt;
    do_start(16'd0);
    check("t4_zero_done", {31'd0, done}, 32'd1);
    check("t4_zero_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    check("t4_zero_no_we", wr_cnt, w0);
    for (int k = 0; k < 256; k++) img[k] = 8'(k ^ 8'h5A);
    do_start(16'd150);
    send_stream(0, 150, 1'b0);
    check_finished("t4_full");
    check("t4_last_addr", {16'd0, bus.mem_addr}, 32'd149);
    @(posedge clk); #1;

    // 5: reset in the middle of a load, then a short reload
    do_start(16'd8);
    send_stream(0, 3, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("t5_abort");
    rst = 1'b0;
    @(posedge clk); #1;
    img[0] = 8'hC3; img[1] = 8'h3C;
    do_start(16'd2);
    send_stream(0, 2, 1'b0);
    check_finished("t5_reload");

    // 6: start during LOAD is ignored; start in DONE restarts with clear
    for (int k = 0; k < 8; k++) img[k] = 8'(8'h11 * (k + 1));
    @(posedge clk); #1;
    do_start(16'd6);
    send_stream(0, 2, 1'b0);
    start = 1'b1;
    len   = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check("t6_ignored_busy", {31'd0, busy}, 32'd1);
    check("t6_ignored_count", {16'd0, byte_count}, 32'd2);
    send_stream(2, 4, 1'b0);
    check_finished("t6_first");
    @(posedge clk); #1;
    do_start(16'd4);
    check("t6_restart_count", {16'd0, byte_count}, 32'd0);
    check("t6_restart_sum", {24'd0, checksum}, 32'd0);
    check("t6_restart_busy", {31'd0, busy}, 32'd1);
    send_stream(4, 4, 1'b0);
    check_finished("t6_second");

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
